west_skew_feeder: RTL and testbench

Activation feeder for the west edge of the systolic PE array. Buffers up to DEPTH activation vectors (one element per array row) and, on start, streams them into the array's inp_west inputs with diagonal skew: row r is delayed r cycles. It drives the array's compute enable and flushes the pipeline with zeros, then pulses done. It is the transmitting end of the PE west-input interface.

---
 rtl/feeder_pkg.sv | 21 ++
 rtl/skew_delay_line.sv | 44 ++++
 rtl/west_skew_feeder.sv | 171 +++++++++++++++++
 tb/tb_west_skew_feeder.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/feeder_pkg.sv
// feeder_pkg: shared definitions for the west-edge activation feeder.
//   DATA_W_DEFAULT : default activation element width
//   feeder_state_t : controller states IDLE / STREAM / FLUSH
//   stream_len()   : number of STREAM cycles for a given vector count
//                    (the last vector needs rows-1 extra cycles to reach
//                    the bottom row through the skew)
package feeder_pkg;

    localparam int DATA_W_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2
    } feeder_state_t;

    function automatic int stream_len(input int count, input int rows);
        return count + rows - 1;
    endfunction

endpackage

// File: rtl/skew_delay_line.sv
// skew_delay_line: STAGES-deep register chain for one array row.
//   clk  : clock
//   rst  : synchronous active-high clear of every stage
//   en   : shift enable (low holds the chain contents)
//   din  : element entering the chain
//   dout : element after STAGES cycles; STAGES = 0 is a plain wire
module skew_delay_line #(
    parameter int DATA_W = 32,
    parameter int STAGES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    generate
        if (STAGES == 0) begin : g_pass
            // Row 0 is already registered upstream; nothing to add.
            logic unused_pass;
            assign unused_pass = &{1'b0, clk, rst, en};
            assign dout = din;
        end else begin : g_chain
            logic [DATA_W-1:0] stage_reg [STAGES];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < STAGES; i++) begin
                        stage_reg[i] <= '0;
                    end
                end else if (en) begin
                    stage_reg[0] <= din;
                    for (int i = 1; i < STAGES; i++) begin
                        stage_reg[i] <= stage_reg[i-1];
                    end
                end
            end

            assign dout = stage_reg[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/west_skew_feeder.sv
// west_skew_feeder: buffers activation vectors and streams them into the
// west edge of the systolic array with a diagonal skew (row r lags r cycles),
// then flushes the array with zeros and pulses done.
//   clk, rst   : clock, synchronous active-high reset
//   in_valid / in_ready / in_data : vector write port (IDLE only)
//   start      : begin streaming the buffered vectors
//   west_data  : skewed activations, row r at [r*DATA_W +: DATA_W]
//   compute    : array compute enable
//   busy       : STREAM or FLUSH in progress
//   done       : one-cycle completion pulse
//   stall      : pause the schedule (only when FEEDER_STALL_EN is defined)
// Optional feature macro: FEEDER_STALL_EN.
module west_skew_feeder
    import feeder_pkg::*;
#(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int DEPTH  = 8,
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ROWS*DATA_W-1:0] in_data,
    input  logic                   start,
    output logic [ROWS*DATA_W-1:0] west_data,
    output logic                   compute,
    output logic                   busy,
    output logic                   done
`ifdef FEEDER_STALL_EN
    ,
    input  logic                   stall
`endif
);

    localparam int VEC_W  = ROWS * DATA_W;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int T_W    = $clog2(DEPTH + ROWS + 1);
    localparam int F_W    = (COLS > 1) ? $clog2(COLS) : 1;

    feeder_state_t    state_reg;
    logic [CNT_W-1:0] count_reg;
    logic [T_W-1:0]   t_reg;
    logic [T_W-1:0]   len_reg;
    logic [F_W-1:0]   flush_reg;
    logic             compute_reg;
    logic             busy_reg;
    logic             done_reg;
    logic [VEC_W-1:0] col_reg;
    logic [VEC_W-1:0] mem [DEPTH];

    logic             stall_act;
    logic             wr_en;
    logic [CNT_W-1:0] count_next;
    logic             start_ok;
    logic             stream_last;
    logic [T_W-1:0]   t_next;
    logic [ADDR_W-1:0] rd_addr;
    logic [VEC_W-1:0] rd_data;
    logic             delay_en;

`ifdef FEEDER_STALL_EN
    assign stall_act = stall && (state_reg != IDLE);
`else
    assign stall_act = 1'b0;
`endif

    assign in_ready   = (state_reg == IDLE) && (count_reg < CNT_W'(DEPTH)) && !rst;
    assign wr_en      = in_valid && in_ready;
    assign count_next = count_reg + CNT_W'(wr_en);
    // A write accepted alongside start is part of the stream.
    assign start_ok   = (state_reg == IDLE) && start && !rst && (count_next != '0);

    assign stream_last = (t_reg == len_reg - T_W'(1));
    assign t_next      = t_reg + T_W'(1);
    assign rd_addr     = start_ok ? '0 : t_next[ADDR_W-1:0];

    // The only read/write collision is vector 0 written in the start cycle.
    assign rd_data = (wr_en && (count_reg[ADDR_W-1:0] == rd_addr)) ? in_data : mem[rd_addr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[count_reg[ADDR_W-1:0]] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            count_reg   <= '0;
            t_reg       <= '0;
            len_reg     <= '0;
            flush_reg   <= '0;
            compute_reg <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            col_reg     <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    count_reg <= count_next;
                    if (start_ok) begin
                        state_reg   <= STREAM;
                        t_reg       <= '0;
                        len_reg     <= T_W'(stream_len(int'(count_next), ROWS));
                        col_reg     <= rd_data;
                        busy_reg    <= 1'b1;
                        compute_reg <= 1'b1;
                    end
                end
                STREAM: begin
                    if (stall_act) begin
                        compute_reg <= 1'b0;
                    end else begin
                        compute_reg <= 1'b1;
                        if (stream_last) begin
                            state_reg <= FLUSH;
                            flush_reg <= '0;
                            col_reg   <= '0;
                        end else begin
                            t_reg   <= t_next;
                            // Column t feeds row 0; past the last vector feed zeros.
                            col_reg <= (t_next < T_W'(count_reg)) ? rd_data : '0;
                        end
                    end
                end
                FLUSH: begin
                    if (stall_act) begin
                        compute_reg <= 1'b0;
                    end else if (flush_reg == F_W'(COLS - 1)) begin
                        state_reg   <= IDLE;
                        done_reg    <= 1'b1;
                        busy_reg    <= 1'b0;
                        compute_reg <= 1'b0;
                        count_reg   <= '0;
                    end else begin
                        compute_reg <= 1'b1;
                        flush_reg   <= flush_reg + F_W'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // The delay lines hold with the rest of the schedule during a stall.
    assign delay_en = !stall_act;

    generate
        for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
            skew_delay_line #(
                .DATA_W(DATA_W),
                .STAGES(gi)
            ) u_delay (
                .clk  (clk),
                .rst  (rst),
                .en   (delay_en),
                .din  (col_reg[gi*DATA_W +: DATA_W]),
                .dout (west_data[gi*DATA_W +: DATA_W])
            );
        end
    endgenerate

    assign compute = compute_reg;
    assign busy    = busy_reg;
    assign done    = done_reg;

endmodule

// File: tb/tb_west_skew_feeder.sv
// Testbench for west_skew_feeder: table-driven stream runs checked against a
// scoreboard queue of expected per-cycle outputs, plus hand-written sequences
// for full buffer, reset mid-stream and (with FEEDER_STALL_EN) stall.
module tb_west_skew_feeder;

    localparam int ROWS   = 4;
    localparam int COLS   = 4;
    localparam int DEPTH  = 8;
    localparam int DATA_W = 32;
    localparam int VW     = ROWS * DATA_W;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          start = 1'b0;
    logic [VW-1:0] in_data = '0;
    logic [VW-1:0] west_data;
    logic          in_ready, compute, busy, done;
`ifdef FEEDER_STALL_EN
    logic          stall = 1'b0;
`endif

    west_skew_feeder #(
        .ROWS(ROWS), .COLS(COLS), .DEPTH(DEPTH), .DATA_W(DATA_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .start     (start),
        .west_data (west_data),
        .compute   (compute),
        .busy      (busy),
        .done      (done)
`ifdef FEEDER_STALL_EN
        ,
        .stall     (stall)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [VW-1:0] west;
        logic          compute;
        logic          busy;
        logic          done;
        logic          ready;
    } exp_t;

    typedef struct {
        int n_load;      // vectors written before start
        bit same_cycle;  // one more vector written in the start cycle
        int poke_k;      // cycle after which start is re-pulsed (ignored), -1 none
        int exp_len;     // STREAM cycles
        int exp_done_k;  // cycles after E0 at which done is visible
    } run_rec_t;

    exp_t          exp_q[$];
    logic [VW-1:0] vecs[$];
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Expected output stream after the start edge; cycles k in (ss, ss+sl]
    // are stalled and repeat the previous schedule step with compute low.
    function automatic void push_model(input int n, input int ss, input int sl);
        int len;
        int step;
        len  = n + ROWS - 1;
        step = 0;
        for (int k = 0; k < 1000; k++) begin
            exp_t e;
            bit   stl;
            stl = (k > ss) && (k <= ss + sl);
            if (k > 0 && !stl) step++;
            if (step > len + COLS + 1) break;
            e.west = '0; e.compute = 1'b0; e.busy = 1'b0; e.done = 1'b0; e.ready = 1'b0;
            if (step < len + COLS) begin
                e.busy    = 1'b1;
                e.compute = !stl;
                if (step < len) begin
                    for (int r = 0; r < ROWS; r++) begin
                        int idx;
                        idx = step - r;
                        if (idx >= 0 && idx < n)
                            e.west[r*DATA_W +: DATA_W] = vecs[idx][r*DATA_W +: DATA_W];
                    end
                end
            end else begin
                e.ready = 1'b1;
                e.done  = (step == len + COLS);
            end
            exp_q.push_back(e);
        end
    endfunction

    // Called at a negedge: write one vector, checking in_ready first.
    task automatic load(input logic [VW-1:0] v, input logic exp_ready);
        in_valid = 1'b1;
        in_data  = v;
        #1;
        chk("in_ready_load", {127'd0, in_ready}, {127'd0, exp_ready});
        if (exp_ready) vecs.push_back(v);
        $display("load vec=%h ready=%0b", v, in_ready);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic run_stream(input int id, input bit same, input logic [VW-1:0] extra,
                              input int poke_k, input int ss, input int sl,
                              input int exp_len, input int exp_done_k);
        int n;
        int comp_cyc;
        int done_k;
        int k;
        comp_cyc = 0;
        done_k   = -1;
        k        = 0;
        start    = 1'b1;
        if (same) begin
            in_valid = 1'b1;
            in_data  = extra;
            vecs.push_back(extra);
        end
        n = vecs.size();
        push_model(n, ss, sl);
        while (exp_q.size() > 0) begin
            exp_t e;
            @(negedge clk);
            if (k == 0) begin
                start    = 1'b0;
                in_valid = 1'b0;
            end
            e = exp_q.pop_front();
            chk("west_data", west_data, e.west);
            chk("compute", {127'd0, compute}, {127'd0, e.compute});
            chk("busy", {127'd0, busy}, {127'd0, e.busy});
            chk("done", {127'd0, done}, {127'd0, e.done});
            chk("in_ready", {127'd0, in_ready}, {127'd0, e.ready});
            if (compute === 1'b1) comp_cyc++;
            if (done === 1'b1 && done_k < 0) done_k = k;
`ifdef FEEDER_STALL_EN
            stall = (k >= ss) && (k < ss + sl);
`endif
            start = (k == poke_k);
            k++;
        end
        start = 1'b0;
        chk("compute_cycles", VW'(comp_cyc), VW'(exp_len + COLS));
        chk("done_cycle", VW'(done_k), VW'(exp_done_k));
        $display("run %0d vectors=%0d compute_cycles=%0d done_at=E0+%0d", id, n, comp_cyc, done_k);
        vecs.delete();
    endtask

    run_rec_t tbl[5];

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [VW-1:0] v;
        logic [VW-1:0] v0;
        logic [VW-1:0] v1;
        logic [VW-1:0] ev;

        tbl[0] = '{n_load: 2, same_cycle: 1'b0, poke_k: -1, exp_len: 5,  exp_done_k: 9};
        tbl[1] = '{n_load: 1, same_cycle: 1'b1, poke_k: -1, exp_len: 5,  exp_done_k: 9};
        tbl[2] = '{n_load: 3, same_cycle: 1'b0, poke_k: 3,  exp_len: 6,  exp_done_k: 10};
        tbl[3] = '{n_load: 1, same_cycle: 1'b0, poke_k: -1, exp_len: 4,  exp_done_k: 8};
        tbl[4] = '{n_load: 8, same_cycle: 1'b0, poke_k: -1, exp_len: 11, exp_done_k: 15};

        // Reset held three cycles.
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_west", west_data, '0);
            chk("rst_compute", {127'd0, compute}, '0);
            chk("rst_busy", {127'd0, busy}, '0);
            chk("rst_done", {127'd0, done}, '0);
            chk("rst_in_ready", {127'd0, in_ready}, '0);
        end
        rst = 1'b0;
        #1;
        chk("in_ready_after_rst", {127'd0, in_ready}, {127'd0, 1'b1});
        @(negedge clk);

        // Table-driven stream runs; entry 0 uses vectors {1,2,3,4},{5,6,7,8}.
        for (int i = 0; i < 5; i++) begin
            logic [VW-1:0] extra;
            for (int j = 0; j < tbl[i].n_load; j++) begin
                for (int r = 0; r < ROWS; r++)
                    v[r*DATA_W +: DATA_W] = (i == 0) ? DATA_W'(j*ROWS + r + 1) : DATA_W'($urandom | 1);
                load(v, 1'b1);
            end
            for (int r = 0; r < ROWS; r++) extra[r*DATA_W +: DATA_W] = DATA_W'($urandom | 1);
            run_stream(i, tbl[i].same_cycle, extra, tbl[i].poke_k, -10, 0,
                       tbl[i].exp_len, tbl[i].exp_done_k);
        end

        // Nine back-to-back writes: the ninth is refused.
        for (int j = 0; j < 9; j++) begin
            for (int r = 0; r < ROWS; r++) v[r*DATA_W +: DATA_W] = DATA_W'($urandom | 1);
            load(v, (j < 8) ? 1'b1 : 1'b0);
        end
        run_stream(5, 1'b0, '0, -1, -10, 0, 11, 15);

        // Reset at stream cycle 2.
        for (int r = 0; r < ROWS; r++) v0[r*DATA_W +: DATA_W] = DATA_W'(16'h100 + r);
        for (int r = 0; r < ROWS; r++) v1[r*DATA_W +: DATA_W] = DATA_W'(16'h200 + r);
        load(v0, 1'b1);
        load(v1, 1'b1);
        start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            start = 1'b0;
            chk("mid_busy", {127'd0, busy}, {127'd0, 1'b1});
        end
        ev = '0;
        ev[1*DATA_W +: DATA_W] = v1[1*DATA_W +: DATA_W];
        ev[2*DATA_W +: DATA_W] = v0[2*DATA_W +: DATA_W];
        chk("mid_west_t2", west_data, ev);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_west", west_data, '0);
        chk("mid_rst_busy", {127'd0, busy}, '0);
        chk("mid_rst_compute", {127'd0, compute}, '0);
        chk("mid_rst_done", {127'd0, done}, '0);
        rst = 1'b0;
        start = 1'b1;  // buffer was emptied by reset, so this is ignored
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            start = 1'b0;
            chk("post_rst_busy", {127'd0, busy}, '0);
            chk("post_rst_done", {127'd0, done}, '0);
            chk("post_rst_west", west_data, '0);
        end
        chk("post_rst_ready", {127'd0, in_ready}, {127'd0, 1'b1});
        vecs.delete();
        $display("reset-mid-stream sequence complete");

`ifdef FEEDER_STALL_EN
        // Stall three cycles at stream cycle 1 with two vectors.
        load(v0, 1'b1);
        load(v1, 1'b1);
        run_stream(6, 1'b0, '0, -1, 1, 3, 5, 12);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
